fifo_replay_ctrl: RTL
=====================

# fifo_replay_ctrl

Sequencer for one FIFO pointer pair in the P03 datapath: loads a frame of N words from an upstream stream into the FIFO, then replays the stored frame a programmable number of passes by popping N words, rewinding the read pointer with `fifo_clr`, and repeating. The FIFO is reinitialised at the end of each job. It sits between the input stream source, the FIFO write/read pointer block, and the downstream consumer.

## Interface
- `CNT_W`, 4: width of frame length, pass count and internal counters; matches the FIFO counter/nibble width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `n`  in  CNT_W  frame length N; latched on accepted `start`.
- `passes`  in  CNT_W  replay pass count; latched on accepted `start`; 0 is treated as 1.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  controller accepts upstream word.
- `out_ready`  in  1  downstream can take a word (used only with `FRC_BACKPRESSURE_EN`).
- `fifo_ready`  in  1  FIFO push count equals N.
- `fifo_push`  out  1  FIFO write-pointer increment.
- `fifo_pop`  out  1  FIFO read-pointer increment.
- `fifo_clr`  out  1  FIFO read-pointer rewind to 0.
- `fifo_rst_n`  out  1  active-low FIFO pointer reset; clears both pointers.
- `out_valid`  out  1  a word is being popped this cycle.
- `out_last`  out  1  last pop of the current pass.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at end of job.

## Operation
- States: IDLE, LOAD, REPLAY, REWIND, DONE. State, latched `n`/`passes`, `pop_cnt`, and `pass_cnt` are registers; all outputs are combinational from state and counters.
- IDLE: `start`=1 and `n`≠0 → latch `n`/`passes`, clear `pop_cnt`/`pass_cnt`, go to LOAD. `start`=1 and `n`=0 → go to DONE with no push/pop.
- LOAD: `in_ready` = !`fifo_ready`. `fifo_push` = `in_valid` & `in_ready`. `fifo_ready`=1 → REPLAY. `in_valid`=0 stalls indefinitely.
- REPLAY: `fifo_pop` = `pop_en`, where `pop_en`=1, or `out_ready` with the macro. `out_valid` = `fifo_pop`. Each pop increments `pop_cnt`. `out_last` = `fifo_pop` & (`pop_cnt`==N−1).
  - On the last pop with `pass_cnt`==passes−1 → DONE.
  - On the last pop otherwise → REWIND.
- REWIND: `fifo_clr`=1 for exactly one cycle. `pop_cnt`←0, `pass_cnt`++. Next state REPLAY.
- DONE: `done`=1 and `fifo_rst_n`=0 for one cycle. Next state IDLE.
- `start` outside IDLE is ignored. `n`/`passes` changes after latching have no effect.
- Counters are compared at CNT_W bits. N up to 2^CNT_W−1 and passes up to 2^CNT_W−1 are legal, with no wrap inside a job.
- `rst`=1: next cycle in IDLE, all counters 0. While `rst` is high, `fifo_rst_n`=0 and every other output is 0. Reset mid-job abandons the job with no `done` pulse.

## Timing
- Reset values: `in_ready`, `fifo_push`, `fifo_pop`, `fifo_clr`, `out_valid`, `out_last`, `busy`, `done` = 0; `fifo_rst_n` = 1 after reset is released.
- `start` accepted at cycle t → `busy`=1 from t+1.
- With `in_valid` held high, pushes occur at t+1…t+N. `fifo_ready` rises at t+N+1, when `in_ready` is already 0. First pop occurs at t+N+2.
- Each pass is N pop cycles when unstalled. Each REWIND adds 1 cycle.
- Unstalled job length from accept to `done`: N+1 + passes·N + (passes−1) + 1 cycles. `done` is followed by IDLE, and a new `start` is accepted the cycle after `done`.
- `fifo_clr` never coincides with `fifo_pop`. `fifo_push` never coincides with `fifo_pop`.

## Configuration
- `FRC_BACKPRESSURE_EN` defined: `out_ready` gates pops. `out_ready`=0 in REPLAY holds all outputs and counters, with `fifo_pop`/`out_valid`=0.
- `FRC_BACKPRESSURE_EN` undefined: `out_ready` is ignored, and REPLAY pops every cycle.

## Test plan
- Reset then idle → all outputs 0, `fifo_rst_n`=1, `busy`=0. Assert `rst` mid-REPLAY → IDLE next cycle, no `done` pulse.
- `n`=4, `passes`=2, `in_valid`=1, start at t → pushes at t+1..t+4, pops at t+6..t+9, `fifo_clr` at t+10, pops at t+11..t+14, `out_last` at t+9 and t+14, `done` and `fifo_rst_n`=0 at t+15.
- `n`=3, `passes`=0, `in_valid` toggling 1,0,1,0,1 → exactly 3 pushes, one pass of 3 pops, no `fifo_clr`, one `done`.
- `n`=0, start → `done` at t+1, no push/pop/clr.
- Macro on, `n`=4, `passes`=1, `out_ready` low for 2 cycles mid-pass → exactly 4 pops, `pop_cnt` frozen while `out_ready` is low, `done` delayed by 2 cycles.
- `start` asserted repeatedly during LOAD/REPLAY → ignored. Back-to-back jobs with `start` the cycle after `done` → second job is accepted immediately.

Source files
------------

// File: rtl/fifo_replay_ctrl.sv
// Load-then-replay sequencer for one FIFO pointer pair: loads N words, replays them `passes` times.
// Optional macro FRC_BACKPRESSURE_EN lets out_ready gate pops in REPLAY.
module fifo_replay_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  input  logic [CNT_W-1:0] passes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  input  logic             fifo_ready,
  output logic             fifo_push,
  output logic             fifo_pop,
  output logic             fifo_clr,
  output logic             fifo_rst_n,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, LOAD, REPLAY, REWIND, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, passes_q, pop_cnt, pass_cnt;
  logic             pop_en, last_pop;

`ifdef FRC_BACKPRESSURE_EN
  assign pop_en = out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign pop_en = 1'b1;
`endif

  assign last_pop = (state_q == REPLAY) && pop_en && (pop_cnt == n_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      passes_q <= '0;
      pop_cnt  <= '0;
      pass_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start && (n != '0)) begin
            n_q      <= n;
            // a pass count of zero still replays the frame once
            passes_q <= (passes == '0) ? CNT_W'(1) : passes;
            pop_cnt  <= '0;
            pass_cnt <= '0;
          end
        end
        REPLAY: begin
          if (pop_en) pop_cnt <= pop_cnt + CNT_W'(1);
        end
        REWIND: begin
          pop_cnt  <= '0;
          pass_cnt <= pass_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clr   = 1'b0;
    fifo_rst_n = 1'b1;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (rst) begin
      fifo_rst_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = (n != '0) ? LOAD : DONE;
        end
        LOAD: begin
          busy      = 1'b1;
          in_ready  = !fifo_ready;
          fifo_push = in_valid && !fifo_ready;
          if (fifo_ready) state_d = REPLAY;
        end
        REPLAY: begin
          busy      = 1'b1;
          fifo_pop  = pop_en;
          out_valid = pop_en;
          out_last  = last_pop;
          if (last_pop) state_d = (pass_cnt == passes_q - CNT_W'(1)) ? DONE : REWIND;
        end
        REWIND: begin
          busy     = 1'b1;
          fifo_clr = 1'b1;
          state_d  = REPLAY;
        end
        DONE: begin
          busy       = 1'b1;
          done       = 1'b1;
          fifo_rst_n = 1'b0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
